csa_operand_sequencer: RTL and testbench

- Upstream feeder for the 10-operand carry-save adder (CSA): 8-bit operands in on ten 8-bit inputs, 12-bit Sum plus Co out.
- Accepts operands one at a time over a valid/ready stream and buffers them in a register bank.
- Presents the whole bank in parallel to the CSA, waits a fixed settle time, then captures Sum/Co.
- Returns the captured result over a valid/ready output stream.

---
 rtl/csa_seq_pkg.sv | 15 +
 rtl/csa_operand_bank.sv | 45 ++++
 rtl/csa_operand_sequencer.sv | 150 +++++++++++++++
 tb/tb_csa_operand_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_seq_pkg.sv
// rtl/csa_seq_pkg.sv - shared defaults and FSM state type for the CSA operand sequencer
package csa_seq_pkg;

  localparam int CSA_WIDTH = 8;
  localparam int CSA_N_OPS = 10;
  localparam int CSA_SUM_W = 12;
  localparam int CNT_W     = $clog2(CSA_N_OPS);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/csa_operand_bank.sv
// rtl/csa_operand_bank.sv - N_OPS x WIDTH operand register file feeding the CSA
// Optional macro CSA_SEQ_EARLY_LAST_EN adds a clear-above-index input for short frames.
module csa_operand_bank import csa_seq_pkg::*; #(
  parameter int WIDTH = CSA_WIDTH,
  parameter int N_OPS = CSA_N_OPS,
  parameter int IDX_W = CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr_all,
`ifdef CSA_SEQ_EARLY_LAST_EN
  input  logic                   clr_above,
`endif
  output logic [N_OPS*WIDTH-1:0] ops
);

  logic [WIDTH-1:0] slot [N_OPS];

  // Slot update: clear-all wins, then the indexed write, then the optional tail clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OPS; k++) slot[k] <= '0;
    end else begin
      for (int k = 0; k < N_OPS; k++) begin
        if (clr_all) begin
          slot[k] <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(k))) begin
          slot[k] <= wr_data;
`ifdef CSA_SEQ_EARLY_LAST_EN
        end else if (clr_above && (IDX_W'(k) > wr_idx)) begin
          slot[k] <= '0;
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < N_OPS; g++) begin : g_flat
    assign ops[g*WIDTH +: WIDTH] = slot[g];
  end

endmodule

// File: rtl/csa_operand_sequencer.sv
// rtl/csa_operand_sequencer.sv - streams operands into a bank, lets the CSA settle, returns Sum/Co
// Optional macro CSA_SEQ_EARLY_LAST_EN lets in_last close a frame before all N_OPS slots are written.
module csa_operand_sequencer import csa_seq_pkg::*; #(
  parameter int WIDTH         = CSA_WIDTH,
  parameter int N_OPS         = CSA_N_OPS,
  parameter int SUM_W         = CSA_SUM_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic [N_OPS*WIDTH-1:0] csa_ops,
  input  logic [SUM_W-1:0]       csa_sum,
  input  logic                   csa_co,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       out_sum,
  output logic                   out_co,
  output logic                   busy
);

  localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_OPS - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             run;
  logic [IDX_W-1:0] cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             accept;
  logic             load_done;
  logic             capture;
  logic             bank_clear;

`ifdef CSA_SEQ_EARLY_LAST_EN
  logic             clr_above;
`else
  logic             unused_in_last;
  assign unused_in_last = in_last;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Keeps in_ready low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    load_done  = 1'b0;
    capture    = 1'b0;
    bank_clear = 1'b0;
`ifdef CSA_SEQ_EARLY_LAST_EN
    clr_above  = 1'b0;
`endif
    case (state)
      LOAD: begin
        in_ready = run;
        if (in_valid && run) begin
          accept = 1'b1;
          if (cnt == LAST_IDX) begin
            load_done = 1'b1;
            state_nxt = SETTLE;
`ifdef CSA_SEQ_EARLY_LAST_EN
          end else if (in_last) begin
            load_done = 1'b1;
            clr_above = 1'b1;
            state_nxt = SETTLE;
`endif
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          bank_clear = 1'b1;
          state_nxt  = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Slot counter walks the bank during LOAD and rewinds when a frame closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (accept) cnt <= load_done ? '0 : cnt + IDX_W'(1);
  end

  // Settle counter measures the CSA propagation window after the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 settle_cnt <= '0;
    else if (load_done)         settle_cnt <= '0;
    else if (state == SETTLE)   settle_cnt <= settle_cnt + SET_W'(1);
  end

  // Result registers: capture once per frame, keep value after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_co    <= 1'b0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_sum   <= csa_sum;
      out_co    <= csa_co;
      out_valid <= 1'b1;
    end else if (bank_clear) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state == SETTLE) || (state == HOLD);

  csa_operand_bank #(
    .WIDTH (WIDTH),
    .N_OPS (N_OPS),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (accept),
    .wr_idx    (cnt),
    .wr_data   (in_data),
    .clr_all   (bank_clear),
`ifdef CSA_SEQ_EARLY_LAST_EN
    .clr_above (clr_above),
`endif
    .ops       (csa_ops)
  );

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// tb/tb_csa_operand_sequencer.sv - randomized self-checking bench for csa_operand_sequencer
module tb_csa_operand_sequencer;

  localparam int WIDTH         = 8;
  localparam int N_OPS         = 10;
  localparam int SUM_W         = 12;
  localparam int SETTLE_CYCLES = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data = '0;
  logic                   in_last = 1'b0;
  logic [N_OPS*WIDTH-1:0] csa_ops;
  logic [SUM_W-1:0]       csa_sum;
  logic                   csa_co;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [SUM_W-1:0]       out_sum;
  logic                   out_co;
  logic                   busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic co_force = 1'b0;
  int   frame[$];
  logic [SUM_W:0] csa_total;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CSA: plain sum of the presented bank, carry from the extra bit (co_force injects a carry)
  always_comb begin
    csa_total = '0;
    for (int k = 0; k < N_OPS; k++) csa_total = csa_total + (SUM_W+1)'(csa_ops[k*WIDTH +: WIDTH]);
  end
  assign csa_sum = csa_total[SUM_W-1:0];
  assign csa_co  = csa_total[SUM_W] | co_force;

  csa_operand_sequencer #(
    .WIDTH(WIDTH), .N_OPS(N_OPS), .SUM_W(SUM_W), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .csa_ops(csa_ops), .csa_sum(csa_sum), .csa_co(csa_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co),
    .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic send_op(input logic [WIDTH-1:0] d, input logic last);
    int  n = 0;
    bit  ok = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (n < 50 && !ok) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: operand %0d not accepted within 50 cycles", d);
    end
  endtask

  task automatic run_frame(input string name, input bit use_last, input bit ready_early,
                           input int gap_max, input int hold_cycles, input logic co_f);
    int                     exp_sum = 0;
    int                     lat = 0;
    logic [N_OPS*WIDTH-1:0] exp_bank = '0;
    logic [SUM_W-1:0]       exp_s;
    co_force  = co_f;
    out_ready = ready_early;
    for (int i = 0; i < frame.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      send_op(WIDTH'(frame[i]), use_last && (i == frame.size() - 1));
      exp_sum += frame[i];
      exp_bank[i*WIDTH +: WIDTH] = WIDTH'(frame[i]);
    end
    exp_s = SUM_W'(exp_sum);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid: got %b want 0", name, out_valid); end
    checks++; if (csa_ops !== exp_bank) begin errors++; $display("FAIL %s bank: got %h want %h", name, csa_ops, exp_bank); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_settle: got %b want 1", name, busy); end
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != SETTLE_CYCLES) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, SETTLE_CYCLES); end
    checks++; if (out_sum !== exp_s) begin errors++; $display("FAIL %s sum: got %0d want %0d", name, out_sum, exp_s); end
    checks++; if (out_co !== co_f) begin errors++; $display("FAIL %s co: got %b want %b", name, out_co, co_f); end
    if (!ready_early) begin
      in_valid = 1'b1; in_data = 8'hAA;
      for (int c = 0; c < hold_cycles; c++) begin
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready, out_sum, out_co} !== {1'b1, 1'b0, exp_s, co_f}) begin
          errors++;
          $display("FAIL %s hold_stable: got v=%b r=%b s=%0d c=%b want v=1 r=0 s=%0d c=%b",
                   name, out_valid, in_ready, out_sum, out_co, exp_s, co_f);
        end
        checks++; if (csa_ops !== exp_bank) begin errors++; $display("FAIL %s hold_bank: got %h want %h", name, csa_ops, exp_bank); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    co_force  = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s valid_drop: got %b want 0", name, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_back: got %b want 1", name, in_ready); end
    checks++; if (csa_ops !== '0) begin errors++; $display("FAIL %s bank_cleared: got %h want 0", name, csa_ops); end
    checks++; if (out_sum !== exp_s) begin errors++; $display("FAIL %s sum_retained: got %0d want %0d", name, out_sum, exp_s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_idle: got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (csa_ops !== '0) begin errors++; $display("FAIL reset_csa_ops: got %h want 0", csa_ops); end
    checks++; if ({out_sum, out_co} !== '0) begin errors++; $display("FAIL reset_result: got %0d/%b want 0/0", out_sum, out_co); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_delay: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b want 1", in_ready); end
  endtask

  task automatic test_basic_sum();
    frame = {};
    for (int v = 1; v <= 10; v++) frame.push_back(v);
    run_frame("seq_1_to_10", 1'b0, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_zero_slots();
    frame = {0, 0, 3, 4, 5, 6, 7, 8, 9, 10};
    run_frame("leading_zeros", 1'b0, 1'b1, 1, 0, 1'b0);
  endtask

  task automatic test_all_ff();
    frame = {};
    for (int i = 0; i < N_OPS; i++) frame.push_back(255);
    run_frame("all_ff", 1'b0, 1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_hold_stall();
    frame = {};
    for (int i = 0; i < N_OPS; i++) frame.push_back(int'($urandom_range(255, 0)));
    run_frame("hold_stall", 1'b0, 1'b0, 0, 5, 1'b0);
  endtask

  task automatic test_carry_passthrough();
    frame = {};
    for (int i = 0; i < N_OPS; i++) frame.push_back(int'($urandom_range(255, 0)));
    run_frame("carry_pass", 1'b0, 1'b0, 1, 2, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    bit seen = 0;
    for (int v = 1; v <= 4; v++) send_op(WIDTH'(v), 1'b0);
    rst_n = 1'b0; #1;
    checks++; if (csa_ops !== '0) begin errors++; $display("FAIL midload_bank: got %h want 0", csa_ops); end
    checks++; if ({in_ready, out_valid, busy} !== 3'b000) begin errors++; $display("FAIL midload_ctrl: got %b want 000", {in_ready, out_valid, busy}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int v = 1; v <= 10; v++) send_op(WIDTH'(v), 1'b0);
    rst_n = 1'b0; #1;
    checks++; if (csa_ops !== '0) begin errors++; $display("FAIL midsettle_bank: got %h want 0", csa_ops); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL reset_no_output: got out_valid=1 want never"); end
    frame = {};
    for (int v = 1; v <= 10; v++) frame.push_back(v);
    run_frame("after_reset", 1'b0, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_early_last();
`ifdef CSA_SEQ_EARLY_LAST_EN
    frame = {1, 2, 3};
    run_frame("early_last", 1'b1, 1'b0, 0, 1, 1'b0);
`else
    logic [N_OPS*WIDTH-1:0] exp_bank = '0;
    int lat = 0;
    for (int v = 1; v <= 3; v++) begin
      send_op(WIDTH'(v), v == 3);
      exp_bank[(v-1)*WIDTH +: WIDTH] = WIDTH'(v);
    end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin errors++; $display("FAIL last_ignored_ctrl: got %b want 001", {out_valid, busy, in_ready}); end
    checks++; if (csa_ops !== exp_bank) begin errors++; $display("FAIL last_ignored_bank: got %h want %h", csa_ops, exp_bank); end
    for (int v = 4; v <= 10; v++) send_op(WIDTH'(v), 1'b0);
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != SETTLE_CYCLES) begin errors++; $display("FAIL last_ignored_latency: got %0d want %0d", lat, SETTLE_CYCLES); end
    checks++; if (out_sum !== SUM_W'(55)) begin errors++; $display("FAIL last_ignored_sum: got %0d want 55", out_sum); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
`endif
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      frame = {};
      for (int i = 0; i < N_OPS; i++) frame.push_back(int'($urandom_range(255, 0)));
      run_frame($sformatf("random_%0d", f), 1'b0, 1'($urandom_range(1, 0)),
                2, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_back_to_back();
    int times[$];
    int sums[$];
    int vals[$];
    int exp[3];
    for (int f = 0; f < 3; f++) begin
      exp[f] = 0;
      for (int i = 0; i < N_OPS; i++) begin
        int v = int'($urandom_range(255, 0));
        vals.push_back(v);
        exp[f] += v;
      end
    end
    out_ready = 1'b1;
    fork
      begin
        foreach (vals[i]) send_op(WIDTH'(vals[i]), 1'b0);
      end
      begin
        repeat (60) begin
          @(posedge clk); #1;
          if (out_valid) begin times.push_back(cyc); sums.push_back(int'(out_sum)); end
        end
      end
    join
    out_ready = 1'b0;
    checks++; if (times.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", times.size()); end
    for (int f = 0; f < 3 && f < sums.size(); f++) begin
      checks++; if (sums[f] != exp[f]) begin errors++; $display("FAIL b2b_sum_%0d: got %0d want %0d", f, sums[f], exp[f]); end
    end
    for (int f = 1; f < times.size(); f++) begin
      checks++;
      if (times[f] - times[f-1] != N_OPS + SETTLE_CYCLES + 1) begin
        errors++; $display("FAIL b2b_period_%0d: got %0d want %0d", f, times[f] - times[f-1], N_OPS + SETTLE_CYCLES + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_zero_slots();
    test_all_ff();
    test_hold_stall();
    test_carry_passthrough();
    test_reset_mid_frame();
    test_early_last();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
